// File: rtl/seq_accum_ctrl_pkg.sv
// Shared definitions for the sequence accumulator controller and its datapath.
package seq_accum_ctrl_pkg;

  // Default datapath and length-field widths.
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 4;

  // Controller state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_ACC   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    CLEAR = ST_CLEAR,
    ACC   = ST_ACC,
    DONE  = ST_DONE
  } state_t;

endpackage : seq_accum_ctrl_pkg

// File: rtl/seq_accum_dp.sv
// Accumulator datapath: WIDTH-bit adder feeding a register with synchronous
// clear and enable. carry is the carry-out of the addition that would be
// committed by en this cycle.
module seq_accum_dp
  import seq_accum_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] acc,
  output logic             carry
);

  logic [WIDTH:0] sum_ext;

  // One extra bit so the carry-out falls out of the same adder.
  assign sum_ext = {1'b0, acc} + {1'b0, d};
  assign carry   = sum_ext[WIDTH];

  // Accumulator register; clear wins over enable.
  // NOTE: sequential state is written with <= only, so every register in the
  // block samples the values from before the edge regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum_ext[WIDTH-1:0];
    end
  end

endmodule : seq_accum_dp

// File: rtl/seq_accum_ctrl.sv
// Sequencing controller for the 8-bit sequence adder/accumulator. Takes a job
// of len operands, clears the accumulator, accepts operands over a
// valid/ready handshake, then presents the sum with a sticky overflow flag
// until the consumer acknowledges it.
module seq_accum_ctrl
  import seq_accum_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             busy
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             handshake;
  logic             dp_clr;
  logic             dp_en;
  logic [WIDTH-1:0] acc;
  logic             carry;

  // in_ready is a registered copy of "state == ACC", so the handshake never
  // depends combinationally on in_valid feeding back into in_ready.
  assign handshake = in_valid & in_ready;

  // Clear on entry to a job: in CLEAR, or straight from IDLE for a zero-length
  // job that jumps directly to DONE.
  assign dp_clr = (state == CLEAR) ||
                  ((state == IDLE) && start && (len == '0));

  // abort beats a simultaneous handshake: the offered operand is dropped.
  assign dp_en  = (state == ACC) && handshake && !abort;

  seq_accum_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (dp_clr),
    .en    (dp_en),
    .d     (in_data),
    .acc   (acc),
    .carry (carry)
  );

  // The accumulator register already holds still outside ACC, so it doubles as
  // the held result in DONE.
  assign result   = acc;
  assign overflow = ovf;

  // Job sequencing, remaining-operand count, sticky overflow and the
  // registered Moore outputs, all updated together on each edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      cnt          <= '0;
      ovf          <= 1'b0;
      in_ready     <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              cnt   <= len;
              state <= CLEAR;
            end else begin
              ovf          <= 1'b0;
              result_valid <= 1'b1;
              state        <= DONE;
            end
          end
        end

        CLEAR: begin
          ovf <= 1'b0;
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            in_ready <= 1'b1;
            state    <= ACC;
          end
        end

        ACC: begin
          if (abort) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (handshake) begin
            ovf <= ovf | carry;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              in_ready     <= 1'b0;
              result_valid <= 1'b1;
              state        <= DONE;
            end
          end
        end

        DONE: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end

        default: begin
          in_ready     <= 1'b0;
          result_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule : seq_accum_ctrl

// File: tb/tb_seq_accum_ctrl.sv
// Self-checking bench for seq_accum_ctrl: a table of directed jobs, random
// jobs against an arithmetic reference model, and hand-written sequences for
// latency, hold/ack, abort and asynchronous reset.
module tb_seq_accum_ctrl;

  typedef logic [15:0][7:0] ops_t;

  typedef struct {
    string      name;
    int         n;
    int         gap;
    ops_t       ops;
    logic [7:0] res;
    logic       ovf;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0;
  logic [3:0] len_s = '0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic [7:0] result;
  logic       overflow;
  logic       result_valid;
  logic       result_ack = 1'b0;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  seq_accum_ctrl #(
    .WIDTH (8),
    .CNT_W (4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .len          (len_s),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .result       (result),
    .overflow     (overflow),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(input string nm, input int n, input int gap,
                              input logic [127:0] ops, input logic [7:0] r,
                              input logic o);
    vec_t v;
    v.name = nm;
    v.n    = n;
    v.gap  = gap;
    v.ops  = ops;
    v.res  = r;
    v.ovf  = o;
    return v;
  endfunction

  // Reference: running sum as a plain integer, wrapping at 256 and noting
  // every wrap.
  function automatic void model(input int n, input ops_t ops,
                                output logic [7:0] r, output logic o);
    int s;
    s = 0;
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = s + int'(ops[i]);
      if (s > 255) begin
        o = 1'b1;
        s = s - 256;
      end
    end
    r = s[7:0];
  endfunction

  // Run a whole job from IDLE, including the acknowledge. ok reports that
  // every bounded wait completed; rdy_hold that in_ready stayed high through
  // every stall cycle.
  task automatic run_job(input int n, input ops_t ops, input int gap,
                         output logic [7:0] r, output logic o,
                         output logic ok, output logic rdy_hold);
    int t;
    ok       = 1'b1;
    rdy_hold = 1'b1;
    start    = 1'b1;
    len_s    = 4'(n);
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!in_ready && t < 10) begin
        tick();
        t++;
      end
      if (!in_ready) ok = 1'b0;
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          tick();
          if (!in_ready) rdy_hold = 1'b0;
        end
      end
      in_valid = 1'b1;
      in_data  = ops[i];
      tick();
      in_valid = 1'b0;
    end
    t = 0;
    while (!result_valid && t < 10) begin
      tick();
      t++;
    end
    if (!result_valid) ok = 1'b0;
    r = result;
    o = overflow;
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  vec_t       vecs[10];
  logic [7:0] r;
  logic       o;
  logic       ok;
  logic       rh;
  logic [7:0] exp_r;
  logic       exp_o;
  ops_t       rops;
  int         rn;
  int         rgap;

  initial begin
    vecs[0] = mk("basic",      5, 0, {8'd16, 8'd8, 8'd4, 8'd2, 8'd1}, 8'd31,  1'b0);
    vecs[1] = mk("ovf_200_100", 2, 0, {8'd100, 8'd200},                8'd44,  1'b1);
    vecs[2] = mk("after_ovf",  1, 0, {8'd3},                          8'd3,   1'b0);
    vecs[3] = mk("stall",      3, 2, {8'd5, 8'd4, 8'd3},              8'd12,  1'b0);
    vecs[4] = mk("zero_len",   0, 0, 128'd0,                          8'd0,   1'b0);
    vecs[5] = mk("128_128",    2, 1, {8'd128, 8'd128},                8'd0,   1'b1);
    vecs[6] = mk("exact_wrap", 2, 0, {8'd1, 8'd255},                  8'd0,   1'b1);
    vecs[7] = mk("max_operand", 1, 0, {8'd255},                       8'd255, 1'b0);
    vecs[8] = mk("len_max",   15, 0, {16{8'd17}},                     8'd255, 1'b0);
    vecs[9] = mk("sticky_ovf", 3, 0, {8'd1, 8'd255, 8'd1},            8'd1,   1'b1);

    // Reset state, sampled while RST is still low.
    #12;
    check("rst_busy",         busy,         0);
    check("rst_in_ready",     in_ready,     0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result",       result,       0);
    check("rst_overflow",     overflow,     0);
    @(negedge CLK);
    RST = 1'b1;
    tick();

    // Directed job table.
    foreach (vecs[i]) begin
      run_job(vecs[i].n, vecs[i].ops, vecs[i].gap, r, o, ok, rh);
      check({vecs[i].name, "_done"},     ok, 1);
      check({vecs[i].name, "_result"},   r,  vecs[i].res);
      check({vecs[i].name, "_overflow"}, o,  vecs[i].ovf);
      check({vecs[i].name, "_rdy_hold"}, rh, 1);
      check({vecs[i].name, "_idle"},     busy, 0);
    end

    // Latency and busy timing for the basic job, then hold/ack behaviour.
    start = 1'b1;
    len_s = 4'd5;
    tick();
    start = 1'b0;
    check("lat_clear_ready", in_ready, 0);
    check("lat_clear_busy",  busy,     1);
    tick();
    check("lat_acc_ready", in_ready, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(1 << i);
      tick();
      check($sformatf("lat_rv_after_%0d", i + 1), result_valid, (i == 4) ? 1 : 0);
    end
    in_valid = 1'b0;
    check("lat_result", result, 31);
    for (int c = 0; c < 10; c++) begin
      start = (c == 3);
      abort = (c == 5);
      len_s = 4'd5;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check($sformatf("hold_%0d", c), {result_valid, result}, {1'b1, 8'd31});
    end
    result_ack = 1'b1;
    check("hold_busy_before_ack", busy, 1);
    tick();
    result_ack = 1'b0;
    check("ack_busy", busy, 0);
    check("ack_rv",   result_valid, 0);
    tick();
    check("done_start_ignored", busy, 0);
    run_job(1, ops_t'({8'd7}), 0, r, o, ok, rh);
    check("post_ack_result", r, 7);
    check("post_ack_done",   ok, 1);

    // Zero-length job after an overflowing one: one edge to DONE, no in_ready.
    run_job(2, ops_t'({8'd200, 8'd200}), 0, r, o, ok, rh);
    check("pre_zero_ovf", o, 1);
    start = 1'b1;
    len_s = 4'd0;
    tick();
    start = 1'b0;
    check("zero_rv",       result_valid, 1);
    check("zero_in_ready", in_ready,     0);
    check("zero_result",   result,       0);
    check("zero_overflow", overflow,     0);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;

    // Abort after two of four operands.
    start = 1'b1;
    len_s = 4'd4;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 8'd10;
    tick();
    in_data = 8'd20;
    tick();
    in_valid = 1'b0;
    abort    = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_rv",   result_valid, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("abort_quiet_%0d", c), {busy, result_valid}, 0);
    end

    // Abort together with the handshake of the final operand.
    start = 1'b1;
    len_s = 4'd2;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 8'd5;
    tick();
    in_data = 8'd9;
    abort   = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_prio", {busy, result_valid}, 0);
    run_job(1, ops_t'({8'd1}), 0, r, o, ok, rh);
    check("after_abort_result",   r, 1);
    check("after_abort_overflow", o, 0);

    // Abort while in CLEAR.
    start = 1'b1;
    len_s = 4'd3;
    tick();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_clear_busy", busy, 0);
    tick();
    check("abort_clear_ready", in_ready, 0);

    // Asynchronous reset in the middle of ACC.
    start = 1'b1;
    len_s = 4'd4;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 8'd50;
    tick();
    #2;
    RST = 1'b0;
    #1;
    check("async_rst_outputs", {busy, in_ready, result_valid}, 0);
    in_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    tick();
    run_job(2, ops_t'({8'd4, 8'd3}), 0, r, o, ok, rh);
    check("post_rst_result",   r, 7);
    check("post_rst_overflow", o, 0);
    check("post_rst_done",     ok, 1);

    // Random jobs against the reference model.
    for (int k = 0; k < 40; k++) begin
      rn   = int'($urandom_range(0, 15));
      rgap = int'($urandom_range(0, 2));
      for (int i = 0; i < 16; i++) begin
        rops[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255))
                                              : 8'($urandom);
      end
      model(rn, rops, exp_r, exp_o);
      run_job(rn, rops, rgap, r, o, ok, rh);
      check($sformatf("rand%0d_done", k),     ok, 1);
      check($sformatf("rand%0d_result", k),   r,  exp_r);
      check($sformatf("rand%0d_overflow", k), o,  exp_o);
      check($sformatf("rand%0d_rdy_hold", k), rh, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_seq_accum_ctrl
